// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN accelerator input path.
package cnn_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic {FILL, RUN} state_t;
    // Slot of each window pixel in the packed window bus (accelerator input1..input4)
    localparam int WIN_TL = 0;
    localparam int WIN_TR = 1;
    localparam int WIN_BL = 2;
    localparam int WIN_BR = 3;
endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: one image row of storage; combinational read of the old entry, synchronous write.
module line_buffer_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/window2x2_line_buffer.sv
// window2x2_line_buffer: turns a raster pixel stream into 2x2 stride-1 windows
// using a single row line buffer and one registered output stage.
module window2x2_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] win_tl,
    output logic [DATA_W-1:0] win_tr,
    output logic [DATA_W-1:0] win_bl,
    output logic [DATA_W-1:0] win_br,
    output logic              frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic [DATA_W-1:0]          top_left_q, top_left_d;
    logic [DATA_W-1:0]          cur_left_q, cur_left_d;
    logic [3:0][DATA_W-1:0]     win_q, win_d;
    logic                       out_valid_q, out_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic [DATA_W-1:0]          top_pix;
    logic                       accept, emit, col_last, row_last;

    line_buffer_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_line_buf (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (in_data),
        .rdata_o (top_pix)
    );

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign win_tl     = win_q[WIN_TL];
    assign win_tr     = win_q[WIN_TR];
    assign win_bl     = win_q[WIN_BL];
    assign win_br     = win_q[WIN_BR];

    always_comb begin
        accept       = in_valid && in_ready && !clr;
        col_last     = col_q == CW'(IMG_W - 1);
        row_last     = row_q == RW'(IMG_H - 1);
        emit         = accept && state_q == RUN && col_q != '0;
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        top_left_d   = top_left_q;
        cur_left_d   = cur_left_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q && !out_ready;
        frame_done_d = 1'b0;
        if (clr) begin
            state_d     = FILL;
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            col_d        = col_last ? '0 : col_q + 1'b1;
            row_d        = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
            top_left_d   = top_pix;
            cur_left_d   = in_data;
            frame_done_d = col_last && row_last;
            // End of row 0 enters RUN; end of the last row returns to FILL
            if (col_last) state_d = row_last ? FILL : RUN;
            if (emit) begin
                win_d[WIN_TL] = top_left_q;
                win_d[WIN_TR] = top_pix;
                win_d[WIN_BL] = cur_left_q;
                win_d[WIN_BR] = in_data;
                out_valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            top_left_q   <= '0;
            cur_left_q   <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            top_left_q   <= top_left_d;
            cur_left_q   <= cur_left_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
